fb_scan_arbiter: RTL and testbench

Shares the single-port Pong framebuffer between two requesters: the display scanner and the game-logic writer. The display scanner walks x/y pixel addresses across the frame. The game-logic writer draws the paddles and the ball. The block owns the scan x/y counters and the framebuffer address, write-enable and data lines, and sequences one access per clock. It sits between the VGA timing front end, the game FSM and the framebuffer RAM.

---
 rtl/fb_pkg.sv | 27 ++
 rtl/fb_scan_counter.sv | 47 ++++
 rtl/fb_scan_arbiter.sv | 177 +++++++++++++++++
 tb/tb_fb_scan_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: shared constants, FSM state type and the coordinate
// to address helper for the Pong framebuffer scan arbiter.
package fb_pkg;

   localparam int DEF_X_MAX  = 320;
   localparam int DEF_Y_MAX  = 240;
   localparam int DEF_ADDR_W = 17;
   localparam int DEF_DATA_W = 4;
   localparam int DEF_STARVE = 16;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      LINE_GAP,
      DONE
   } fb_state_t;

   // Row-major framebuffer address: y*x_max + x.
   function automatic logic [31:0] coord_addr(
      input logic [9:0]  x,
      input logic [9:0]  y,
      input int unsigned x_max
   );
      return ({22'd0, y} * x_max) + {22'd0, x};
   endfunction

endpackage

// File: rtl/fb_scan_counter.sv
// fb_scan_counter: scan x/y position with a running address.
// Ports: clk, reset, clear, advance (next pixel), next_line (y+1),
//        x, y, addr, last_x / last_y flags.
module fb_scan_counter #(
   parameter int X_MAX  = 320,
   parameter int Y_MAX  = 240,
   parameter int ADDR_W = 17
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              advance,
   input  logic              next_line,
   output logic [9:0]        x,
   output logic [9:0]        y,
   output logic [ADDR_W-1:0] addr,
   output logic              last_x,
   output logic              last_y
);

   assign last_x = (x == 10'(X_MAX - 1));
   assign last_y = (y == 10'(Y_MAX - 1));

   // The address simply counts pixels, so line ends need no
   // multiply; it returns to 0 after the very last pixel.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         x    <= '0;
         y    <= '0;
         addr <= '0;
      end else begin
         if (advance) begin
            if (last_x) begin
               x    <= '0;
               addr <= last_y ? '0 : addr + 1'b1;
            end else begin
               x    <= x + 10'd1;
               addr <= addr + 1'b1;
            end
         end
         if (next_line) begin
            y <= y + 10'd1;
         end
      end
   end

endmodule

// File: rtl/fb_scan_arbiter.sv
// fb_scan_arbiter: shares the single-port framebuffer between the
// display scanner (pix_*) and the game writer (wr_*), driving fb_*.
// Optional macro FB_STARVE_GUARD_EN forces a writer grant after
// STARVE_MAX consecutive denied cycles.
module fb_scan_arbiter
   import fb_pkg::*;
#(
   parameter int X_MAX      = DEF_X_MAX,
   parameter int Y_MAX      = DEF_Y_MAX,
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int STARVE_MAX = DEF_STARVE
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              frame_start,
   input  logic              pix_req,
   output logic              pix_valid,
   output logic [DATA_W-1:0] pix_data,
   output logic [9:0]        pix_x,
   output logic [9:0]        pix_y,
   output logic              line_done,
   output logic              frame_done,
   input  logic              wr_req,
   input  logic [9:0]        wr_x,
   input  logic [9:0]        wr_y,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ack,
   output logic              wr_err,
   output logic [ADDR_W-1:0] fb_addr,
   output logic              fb_we,
   output logic [DATA_W-1:0] fb_wdata,
   input  logic [DATA_W-1:0] fb_rdata
);

   fb_state_t         state, state_n;
   logic              g_pix, g_wr;
   logic              cnt_clear, cnt_nline;
   logic [9:0]        scan_x, scan_y;
   logic [ADDR_W-1:0] scan_addr, wr_addr;
   logic              last_x, last_y;
   logic              wr_oob, starve;
   logic              pv_q, ld_q, fd_q;
   logic [9:0]        px_q, py_q;

   fb_scan_counter #(
      .X_MAX (X_MAX),
      .Y_MAX (Y_MAX),
      .ADDR_W(ADDR_W)
   ) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .clear    (cnt_clear),
      .advance  (g_pix),
      .next_line(cnt_nline),
      .x        (scan_x),
      .y        (scan_y),
      .addr     (scan_addr),
      .last_x   (last_x),
      .last_y   (last_y)
   );

   assign wr_oob  = (wr_x >= 10'(X_MAX)) || (wr_y >= 10'(Y_MAX));
   assign wr_addr = ADDR_W'(coord_addr(wr_x, wr_y, X_MAX));

`ifdef FB_STARVE_GUARD_EN
   localparam int SW_RAW = $clog2(STARVE_MAX + 1);
   localparam int SW     = (SW_RAW > 5) ? SW_RAW : 5;

   logic [SW-1:0] wait_q;

   // Only a writer that is still asking may steal the slot.
   assign starve = wr_req && (wait_q >= SW'(STARVE_MAX));

   always_ff @(posedge clk) begin
      if (reset) begin
         wait_q <= '0;
      end else if (wr_ack || !wr_req) begin
         wait_q <= '0;
      end else if (wait_q != '1) begin
         wait_q <= wait_q + 1'b1;
      end
   end
`else
   logic unused_starve_max;
   assign unused_starve_max = (STARVE_MAX == 0);
   assign starve = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         pv_q  <= 1'b0;
         ld_q  <= 1'b0;
         fd_q  <= 1'b0;
         px_q  <= '0;
         py_q  <= '0;
      end else begin
         state <= state_n;
         pv_q  <= g_pix;
         ld_q  <= g_pix && last_x;
         fd_q  <= (state == DONE);
         if (g_pix) begin
            px_q <= scan_x;
            py_q <= scan_y;
         end
      end
   end

   always_comb begin
      state_n   = state;
      g_pix     = 1'b0;
      g_wr      = 1'b0;
      cnt_clear = 1'b0;
      cnt_nline = 1'b0;
      unique case (state)
         IDLE: begin
            g_wr = wr_req;
            if (frame_start) begin
               state_n   = SCAN;
               cnt_clear = 1'b1;
            end
         end
         SCAN: begin
            g_pix = pix_req && !starve;
            g_wr  = wr_req && !g_pix;
            if (g_pix && last_x) begin
               state_n = last_y ? DONE : LINE_GAP;
            end
         end
         LINE_GAP: begin
            g_wr      = wr_req;
            cnt_nline = 1'b1;
            state_n   = SCAN;
         end
         DONE: begin
            g_wr      = wr_req;
            cnt_clear = 1'b1;
            state_n   = IDLE;
         end
         default: state_n = IDLE;
      endcase
      if (reset) begin
         g_pix = 1'b0;
         g_wr  = 1'b0;
      end
   end

   always_comb begin
      fb_addr  = '0;
      fb_we    = 1'b0;
      fb_wdata = '0;
      wr_ack   = 1'b0;
      wr_err   = 1'b0;
      if (g_pix) begin
         fb_addr = scan_addr;
      end else if (g_wr) begin
         wr_ack = 1'b1;
         wr_err = wr_oob;
         if (!wr_oob) begin
            fb_we    = 1'b1;
            fb_addr  = wr_addr;
            fb_wdata = wr_data;
         end
      end
   end

   // Registered outputs are masked during reset so a read that
   // was in flight never surfaces.
   assign pix_valid  = pv_q && !reset;
   assign pix_data   = pix_valid ? fb_rdata : '0;
   assign pix_x      = reset ? '0 : px_q;
   assign pix_y      = reset ? '0 : py_q;
   assign line_done  = ld_q && !reset;
   assign frame_done = fd_q && !reset;

endmodule

// File: tb/tb_fb_scan_arbiter.sv
// tb_fb_scan_arbiter: directed plus random stimulus checked against
// a pixel-index reference model of the arbiter.
module tb_fb_scan_arbiter;

   localparam int XM = 4;
   localparam int YM = 2;
   localparam int SM = 3;
`ifdef FB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        frame_start = 1'b0;
   logic        pix_req = 1'b0;
   logic        pix_valid;
   logic [3:0]  pix_data;
   logic [9:0]  pix_x, pix_y;
   logic        line_done, frame_done;
   logic        wr_req = 1'b0;
   logic [9:0]  wr_x = '0, wr_y = '0;
   logic [3:0]  wr_data = '0;
   logic        wr_ack, wr_err;
   logic [16:0] fb_addr;
   logic        fb_we;
   logic [3:0]  fb_wdata;
   logic [3:0]  rd_q = '0;
   logic [3:0]  mem [0:7];

   int n_chk = 0;
   int n_fail = 0;
   int n_pv, n_ld, n_fd;

   // reference model: frame phase, pixel index, framebuffer copy
   int       ph, idx, wcnt;
   bit       e_pv, e_ld, e_fd;
   int       e_pd, e_px, e_py;
   int       refmem [0:7];

   always #5 clk = ~clk;

   fb_scan_arbiter #(
      .X_MAX(XM), .Y_MAX(YM), .ADDR_W(17),
      .DATA_W(4), .STARVE_MAX(SM)
   ) dut (
      .clk(clk), .reset(reset), .frame_start(frame_start),
      .pix_req(pix_req), .pix_valid(pix_valid),
      .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
      .line_done(line_done), .frame_done(frame_done),
      .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y),
      .wr_data(wr_data), .wr_ack(wr_ack), .wr_err(wr_err),
      .fb_addr(fb_addr), .fb_we(fb_we), .fb_wdata(fb_wdata),
      .fb_rdata(rd_q)
   );

   // synchronous single-port RAM, one-cycle read latency
   always @(posedge clk) begin
      rd_q <= mem[fb_addr[2:0]];
      if (fb_we) mem[fb_addr[2:0]] <= fb_wdata;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      ph = 0; idx = 0; wcnt = 0;
      e_pv = 0; e_ld = 0; e_fd = 0;
      e_pd = 0; e_px = 0; e_py = 0;
   endtask

   // one clock: drive at posedge+1, check at negedge, advance model
   task automatic cycle(input bit fs, input bit pr, input bit wq,
                        input int wx, input int wy, input int wd);
      bit st, gp, gw, oob;
      int wa;
      frame_start = fs; pix_req = pr; wr_req = wq;
      wr_x = 10'(wx); wr_y = 10'(wy); wr_data = 4'(wd);
      st  = GUARD && wq && (wcnt >= SM);
      gp  = (ph == 1) && pr && !st;
      gw  = wq && !gp;
      oob = (wx >= XM) || (wy >= YM);
      wa  = wy * XM + wx;
      #4;
      chk("pix_valid", pix_valid, e_pv);
      chk("pix_data", pix_data, e_pv ? e_pd : 0);
      if (e_pv) begin
         chk("pix_x", pix_x, e_px);
         chk("pix_y", pix_y, e_py);
      end
      chk("line_done", line_done, e_ld);
      chk("frame_done", frame_done, e_fd);
      chk("wr_ack", wr_ack, gw);
      chk("wr_err", wr_err, gw && oob);
      chk("fb_we", fb_we, gw && !oob);
      chk("fb_wdata", fb_wdata, (gw && !oob) ? wd % 16 : 0);
      if (!(gw && oob))
         chk("fb_addr", fb_addr, gp ? idx : (gw ? wa : 0));
      n_pv += int'(pix_valid);
      n_ld += int'(line_done);
      n_fd += int'(frame_done);
      if (gw && !oob) refmem[wa] = wd % 16;
      e_pv = gp;
      e_ld = 0;
      e_fd = (ph == 3);
      if (gp) begin
         e_pd = refmem[idx];
         e_px = idx % XM;
         e_py = idx / XM;
         e_ld = (idx % XM == XM - 1);
      end
      case (ph)
         0: if (fs) begin ph = 1; idx = 0; end
         1: if (gp) begin
               idx++;
               if (idx % XM == 0) ph = (idx == XM * YM) ? 3 : 2;
            end
         2: ph = 1;
         default: ph = 0;
      endcase
      wcnt = (gw || !wq) ? 0 : wcnt + 1;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      for (int i = 0; i < n; i++) begin
         frame_start = 1'($urandom);
         pix_req = 1'($urandom);
         wr_req = 1'($urandom);
         wr_x = 10'($urandom_range(0, 3));
         wr_y = 10'($urandom_range(0, 1));
         #4;
         chk("rst_pix_valid", pix_valid, 0);
         chk("rst_pix_data", pix_data, 0);
         chk("rst_pix_x", pix_x, 0);
         chk("rst_pix_y", pix_y, 0);
         chk("rst_line_done", line_done, 0);
         chk("rst_frame_done", frame_done, 0);
         chk("rst_wr_ack", wr_ack, 0);
         chk("rst_wr_err", wr_err, 0);
         chk("rst_fb_we", fb_we, 0);
         chk("rst_fb_addr", fb_addr, 0);
         chk("rst_fb_wdata", fb_wdata, 0);
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      for (int i = 0; i < 8; i++) begin
         mem[i] = '0;
         refmem[i] = 0;
      end
      model_reset();
      @(posedge clk);
      #1;
      do_reset(2);

      // full frame with the display always requesting
      n_pv = 0; n_ld = 0; n_fd = 0;
      cycle(1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 12; i++) cycle(0, 1, 0, 0, 0, 0);
      chk("frame_pix_count", n_pv, 8);
      chk("frame_line_done_count", n_ld, 2);
      chk("frame_done_count", n_fd, 1);

      // writes while idle, including out-of-range coordinates
      cycle(0, 0, 1, 2, 1, 5);
      cycle(0, 0, 1, 4, 0, 3);
      cycle(0, 0, 1, 1, 2, 7);
      cycle(0, 0, 1, 3, 1, 9);
      cycle(0, 0, 0, 0, 0, 0);

      // display and writer contending for a whole frame
      cycle(1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 14; i++)
         cycle(0, 1, 1, i % 4, (i / 4) % 2, i + 1);
      cycle(0, 0, 0, 0, 0, 0);

      // display pauses at x=2; a frame_start mid-scan is ignored
      cycle(1, 1, 0, 0, 0, 0);
      cycle(0, 1, 0, 0, 0, 0);
      cycle(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) cycle(i == 2, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) cycle(0, 1, 0, 0, 0, 0);

      // reset right after a display grant
      cycle(1, 1, 0, 0, 0, 0);
      cycle(0, 1, 0, 0, 0, 0);
      do_reset(1);
      cycle(0, 1, 0, 0, 0, 0);

      // randomized traffic with occasional resets
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 79) == 0) begin
            do_reset(1);
         end else begin
            cycle($urandom_range(0, 5) == 0,
                  $urandom_range(0, 3) != 0,
                  1'($urandom),
                  $urandom_range(0, 5),
                  $urandom_range(0, 2),
                  $urandom_range(0, 15));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
